// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with load scoreboard.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned NREGS_DEF  = 16;
    localparam int unsigned PC_REG_DEF = 15;

    // Register index width for a file of n registers.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_busy_table.sv
// Busy scoreboard: one bit per register, set by load issue, cleared by load return.
module reg_busy_table
    import regfile_pkg::*;
#(
    parameter  int unsigned NREGS  = NREGS_DEF,
    parameter  int unsigned NREAD  = 3,
    parameter  int unsigned PC_REG = PC_REG_DEF,
    localparam int unsigned AW     = addr_w(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [AW-1:0]       set_addr,
    input  logic                clr_en,
    input  logic [AW-1:0]       clr_addr,
    input  logic [NREAD*AW-1:0] rd_addr,
    output logic [NREAD-1:0]    rd_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREAD-1:0] w_rd_busy;

    // A newly issued load is younger than one returning, so set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (i == PC_REG) begin
                    r_busy[i] <= 1'b0;
                end else if (set_en && set_addr == AW'(i)) begin
                    r_busy[i] <= 1'b1;
                end else if (clr_en && clr_addr == AW'(i)) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // A load returning this cycle is forwarded, so its reader need not stall.
    always_comb begin
        w_rd_busy = '0;
        for (int unsigned p = 0; p < NREAD; p++) begin
            w_rd_busy[p] = r_busy[rd_addr[p*AW +: AW]] &&
                           !(clr_en && clr_addr == rd_addr[p*AW +: AW]);
        end
    end

    assign rd_busy = w_rd_busy;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with ALU/load write-back, write bypass,
// load busy scoreboard and PC-write redirect to fetch.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEF,
    parameter  int unsigned NREGS  = NREGS_DEF,
    parameter  int unsigned NREAD  = 3,
    parameter  int unsigned PC_REG = PC_REG_DEF,
    localparam int unsigned AW     = addr_w(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*AW-1:0]     rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic [DATA_W-1:0]       pc_in,
    input  logic                    wa_en,
    input  logic [AW-1:0]           wa_addr,
    input  logic [DATA_W-1:0]       wa_data,
    input  logic                    wb_en,
    input  logic [AW-1:0]           wb_addr,
    input  logic [DATA_W-1:0]       wb_data,
    input  logic                    busy_set_en,
    input  logic [AW-1:0]           busy_set_addr,
    output logic                    pc_wr_valid,
    output logic [DATA_W-1:0]       pc_wr_data
);

    logic [DATA_W-1:0]       r_regs [NREGS];
    logic                    r_pc_wr_valid;
    logic [DATA_W-1:0]       r_pc_wr_data;
    logic                    w_wa_pc;
    logic                    w_wb_pc;
    logic [NREAD*DATA_W-1:0] w_rd_data;
    logic [AW-1:0]           w_addr;

    assign w_wa_pc = wa_en && wa_addr == AW'(PC_REG);
    assign w_wb_pc = wb_en && wb_addr == AW'(PC_REG);

    // Storage and PC redirect; port B (load) wins on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pc_wr_valid <= 1'b0;
            r_pc_wr_data  <= '0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (i != PC_REG) begin
                    if (wb_en && wb_addr == AW'(i)) begin
                        r_regs[i] <= wb_data;
                    end else if (wa_en && wa_addr == AW'(i)) begin
                        r_regs[i] <= wa_data;
                    end
                end
            end
            r_pc_wr_valid <= w_wa_pc || w_wb_pc;
            if (w_wb_pc) begin
                r_pc_wr_data <= wb_data;
            end else if (w_wa_pc) begin
                r_pc_wr_data <= wa_data;
            end
        end
    end

    // Read ports: PC, then load bypass, then ALU bypass, then storage.
    always_comb begin
        w_rd_data = '0;
        w_addr    = '0;
        for (int unsigned p = 0; p < NREAD; p++) begin
            w_addr = rd_addr[p*AW +: AW];
            if (w_addr == AW'(PC_REG)) begin
                w_rd_data[p*DATA_W +: DATA_W] = pc_in;
            end else if (wb_en && wb_addr == w_addr) begin
                w_rd_data[p*DATA_W +: DATA_W] = wb_data;
            end else if (wa_en && wa_addr == w_addr) begin
                w_rd_data[p*DATA_W +: DATA_W] = wa_data;
            end else begin
                w_rd_data[p*DATA_W +: DATA_W] = r_regs[w_addr];
            end
        end
    end

    reg_busy_table #(
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .PC_REG (PC_REG)
    ) u_busy (
        .clk      (clk),
        .rst      (rst),
        .set_en   (busy_set_en),
        .set_addr (busy_set_addr),
        .clr_en   (wb_en),
        .clr_addr (wb_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );

    assign rd_data     = w_rd_data;
    assign pc_wr_valid = r_pc_wr_valid;
    assign pc_wr_data  = r_pc_wr_data;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_regfile_scoreboard;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 16;
    localparam int unsigned NP = 3;
    localparam int unsigned AW = 4;
    localparam int unsigned PC = 15;

    logic              clk;
    logic              rst;
    logic [NP*AW-1:0]  rd_addr;
    logic [NP*DW-1:0]  rd_data;
    logic [NP-1:0]     rd_busy;
    logic [DW-1:0]     pc_in;
    logic              wa_en;
    logic [AW-1:0]     wa_addr;
    logic [DW-1:0]     wa_data;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic              busy_set_en;
    logic [AW-1:0]     busy_set_addr;
    logic              pc_wr_valid;
    logic [DW-1:0]     pc_wr_data;

    logic [AW-1:0]     ra [NP];

    logic [DW-1:0]     m_regs [NR];
    bit                m_busy [NR];
    bit                m_pc_valid;
    logic [DW-1:0]     m_pc_data;

    int                n_checks;
    int                n_pass;

    regfile_scoreboard #(
        .DATA_W (DW),
        .NREGS  (NR),
        .NREAD  (NP),
        .PC_REG (PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_busy       (rd_busy),
        .pc_in         (pc_in),
        .wa_en         (wa_en),
        .wa_addr       (wa_addr),
        .wa_data       (wa_data),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .busy_set_en   (busy_set_en),
        .busy_set_addr (busy_set_addr),
        .pc_wr_valid   (pc_wr_valid),
        .pc_wr_data    (pc_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int p = 0; p < int'(NP); p++) rd_addr[p*AW +: AW] = ra[p];
    end

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    task automatic idle();
        rst = 1'b0; pc_in = '0;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        busy_set_en = 1'b0; busy_set_addr = '0;
        for (int p = 0; p < int'(NP); p++) ra[p] = AW'(p);
    endtask

    // Expected combinational read value from the architectural rules.
    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        if (a == AW'(PC))             return pc_in;
        if (wb_en && wb_addr == a)    return wb_data;
        if (wa_en && wa_addr == a)    return wa_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        return m_busy[a] && !(wb_en && wb_addr == a);
    endfunction

    task automatic compare_model();
        for (int p = 0; p < int'(NP); p++) begin
            check($sformatf("rd_data[%0d] r%0d", p, ra[p]), rd_data[p*DW +: DW], exp_read(ra[p]));
            check($sformatf("rd_busy[%0d] r%0d", p, ra[p]), DW'(rd_busy[p]), DW'(exp_busy(ra[p])));
        end
        check("pc_wr_valid", DW'(pc_wr_valid), DW'(m_pc_valid));
        if (m_pc_valid) check("pc_wr_data", pc_wr_data, m_pc_data);
    endtask

    // Architectural state update at a clock edge.
    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < int'(NR); i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_pc_valid = 1'b0;
            m_pc_data  = '0;
        end else begin
            m_pc_valid = (wa_en && wa_addr == AW'(PC)) || (wb_en && wb_addr == AW'(PC));
            if (wb_en && wb_addr == AW'(PC))      m_pc_data = wb_data;
            else if (wa_en && wa_addr == AW'(PC)) m_pc_data = wa_data;
            if (wa_en && wa_addr != AW'(PC)) m_regs[wa_addr] = wa_data;
            if (wb_en && wb_addr != AW'(PC)) m_regs[wb_addr] = wb_data;
            if (wb_en) m_busy[wb_addr] = 1'b0;
            if (busy_set_en && busy_set_addr != AW'(PC)) m_busy[busy_set_addr] = 1'b1;
        end
    endtask

    task automatic settle();
        #1;
        compare_model();
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(0, 4) == 0) ? AW'(PC) : AW'($urandom_range(0, 7));
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle();
        rst = 1'b1;
        @(negedge clk);
        edge_step();

        // Reset state
        rst = 1'b1;
        settle();
        edge_step();
        idle();
        settle();
        check("reset pc_wr_valid", DW'(pc_wr_valid), 32'h0);
        check("reset pc_wr_data", pc_wr_data, 32'h0);
        check("reset r0", rd_data[0 +: DW], 32'h0);

        // ALU write then read next cycle
        wa_en = 1'b1; wa_addr = 4'd3; wa_data = 32'h1234;
        settle();
        edge_step();
        idle(); ra[0] = 4'd3;
        settle();
        check("r3 after write", rd_data[0 +: DW], 32'h0000_1234);
        rst = 1'b1;
        settle();
        edge_step();
        idle(); ra[0] = 4'd3;
        settle();
        check("r3 after reset", rd_data[0 +: DW], 32'h0);

        // Same-cycle bypass and collision
        wa_en = 1'b1; wa_addr = 4'd5; wa_data = 32'hAAAA; ra[1] = 4'd5;
        settle();
        check("r5 bypass", rd_data[DW +: DW], 32'hAAAA);
        edge_step();
        idle();
        wa_en = 1'b1; wa_addr = 4'd5; wa_data = 32'h1;
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h2;
        settle();
        edge_step();
        idle(); ra[1] = 4'd5;
        settle();
        check("r5 B wins", rd_data[DW +: DW], 32'h2);

        // PC redirect
        wb_en = 1'b1; wb_addr = 4'd15; wb_data = 32'h80; pc_in = 32'h40; ra[2] = 4'd15;
        settle();
        check("r15 reads pc_in", rd_data[2*DW +: DW], 32'h40);
        edge_step();
        idle(); pc_in = 32'h40; ra[2] = 4'd15;
        settle();
        check("pc_wr_valid pulse", DW'(pc_wr_valid), 32'h1);
        check("pc_wr_data", pc_wr_data, 32'h80);
        check("r15 still pc_in", rd_data[2*DW +: DW], 32'h40);
        edge_step();
        idle();
        settle();
        check("pc_wr_valid one cycle", DW'(pc_wr_valid), 32'h0);

        // Scoreboard set, bypassed return, clear
        busy_set_en = 1'b1; busy_set_addr = 4'd7;
        settle();
        edge_step();
        idle(); ra[0] = 4'd7;
        settle();
        check("r7 busy", DW'(rd_busy[0]), 32'h1);
        wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h9;
        settle();
        check("r7 return not busy", DW'(rd_busy[0]), 32'h0);
        check("r7 return data", rd_data[0 +: DW], 32'h9);
        edge_step();
        idle(); ra[0] = 4'd7;
        settle();
        check("r7 cleared", DW'(rd_busy[0]), 32'h0);

        // Set beats clear; reset drops busy
        busy_set_en = 1'b1; busy_set_addr = 4'd2; wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'h5;
        settle();
        edge_step();
        idle(); ra[2] = 4'd2;
        settle();
        check("r2 set wins", DW'(rd_busy[2]), 32'h1);
        rst = 1'b1;
        settle();
        edge_step();
        idle(); ra[2] = 4'd2;
        settle();
        check("r2 busy after reset", DW'(rd_busy[2]), 32'h0);

        // Independent ports including PC
        wa_en = 1'b1; wa_addr = 4'd1; wa_data = 32'h11;
        wb_en = 1'b1; wb_addr = 4'd6; wb_data = 32'h66;
        settle();
        edge_step();
        idle(); ra[0] = 4'd1; ra[1] = 4'd6; ra[2] = 4'd15; pc_in = 32'hCAFE_0000;
        settle();
        check("port0 r1", rd_data[0 +: DW], 32'h11);
        check("port1 r6", rd_data[DW +: DW], 32'h66);
        check("port2 pc", rd_data[2*DW +: DW], 32'hCAFE_0000);
        edge_step();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 99) == 0);
            pc_in         = $urandom;
            wa_en         = ($urandom_range(0, 1) == 1);
            wa_addr       = rand_addr();
            wa_data       = $urandom;
            wb_en         = ($urandom_range(0, 2) == 0);
            wb_addr       = rand_addr();
            wb_data       = $urandom;
            busy_set_en   = ($urandom_range(0, 2) == 0);
            busy_set_addr = rand_addr();
            for (int p = 0; p < int'(NP); p++) ra[p] = rand_addr();
            settle();
            edge_step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the CPU's two-read/one-write register file. It holds the general registers, serves NREAD combinational read ports with same-cycle write bypass, and accepts two write-back ports: ALU and load. It tracks outstanding loads in a busy scoreboard so decode can stall. It redirects writes aimed at the PC register to the fetch unit instead of storing them.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NREGS, 16, architectural register count including PC; power of two, ≥4
- NREAD, 3, number of read ports
- PC_REG, 15, index served from pc_in and never stored

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NREAD*AW  read indices, port i at [i*AW +: AW], AW = $clog2(NREGS)
- rd_data  out  NREAD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NREAD  port i reads a register with a pending load
- pc_in  in  DATA_W  current PC value, returned for reads of PC_REG
- wa_en, wa_addr, wa_data  in  1/AW/DATA_W  write port A (ALU write-back)
- wb_en, wb_addr, wb_data  in  1/AW/DATA_W  write port B (load write-back)
- busy_set_en, busy_set_addr  in  1/AW  load issued to memory; mark target busy
- pc_wr_valid  out  1  registered one-cycle pulse: a write targeted PC_REG
- pc_wr_data  out  DATA_W  data for that PC write

## Operation
- Storage: NREGS−1 stored registers. Index PC_REG has no storage.
- Read port i, combinational, in priority order:
  - addr == PC_REG → pc_in.
  - wb_en && wb_addr == addr → wb_data.
  - wa_en && wa_addr == addr → wa_data.
  - otherwise the stored value.
- Write: on posedge, a non-PC address with its en high is stored. If both ports target the same address, port B wins and port A is dropped.
- PC redirect: a write to PC_REG is not stored. Next cycle pc_wr_valid=1 and pc_wr_data = the winning write's data (B over A). Otherwise pc_wr_valid=0.
- Scoreboard: one busy bit per register. The PC_REG bit is hard-wired 0.
  - busy_set_en sets bit[busy_set_addr].
  - wb_en clears bit[wb_addr].
  - Port A never clears.
  - Set and clear on the same register in the same cycle → set wins, since the new load is younger.
- rd_busy[i] = busy[rd_addr_i] && !(wb_en && wb_addr == rd_addr_i). A load returning this cycle is bypassed, so it does not stall.
- busy_set_addr == PC_REG is ignored.

## Timing
- Read data and rd_busy are combinational from addresses and write ports; 0-cycle latency, including bypass.
- A write is visible in storage from the cycle after the posedge. The bypass covers the write cycle itself.
- Busy set at edge N: rd_busy is asserted from cycle N+1 until the cycle wb_en writes that register, when it deasserts combinationally.
- pc_wr_valid: 1-cycle latency, exactly one cycle wide per PC write.
- Reset, when rst=1 at an edge:
  - all registers 0, all busy bits 0, pc_wr_valid 0, pc_wr_data 0.
  - rst overrides writes and busy sets in the same cycle.
  - Mid-operation reset abandons outstanding loads, with no stale busy bits.
- Reads during reset remain combinational and return pc_in, bypass data, or stored values.

## Structure
- Package regfile_pkg holds:
  - the AW derivation function `addr_w(n)`
  - default constants: DATA_W_DEF, NREGS_DEF, PC_REG_DEF
- Sub-module reg_busy_table holds the NREGS busy bits and contains:
  - set/clear priority logic
  - the per-port rd_busy bypass
  - it is parametrised by NREGS and NREAD
- Top-level regfile_scoreboard holds storage, read muxes, write arbitration and the PC redirect register.

## Test plan
- Reset, then write A r3=0x1234 → read r3 next cycle = 0x00001234. After rst, r3 = 0.
- Same-cycle write A r5=0xAAAA and read r5 → rd_data=0xAAAA in that cycle. A and B both to r5 (0x1, 0x2) → stored 0x2.
- Write B r15=0x80 with pc_in=0x40 → next cycle pc_wr_valid=1 and pc_wr_data=0x80. Read r15 returns 0x40. Nothing is stored.
- busy_set r7 → rd_busy=1 for reads of r7. wb r7=0x9 → same cycle rd_busy=0 and rd_data=0x9. Next cycle busy cleared.
- busy_set r2 and wb r2 in the same cycle → bit stays set and rd_busy=1 next cycle. Reset with r2 busy → rd_busy=0 after reset.
- NREAD=3 with all ports reading distinct registers, including PC_REG → each port returns independent correct data.
